// File: rtl/alu_sequencer_if.sv
// Request, ALU and writeback signals shared by the sequencer and its surroundings.
// The slave view belongs to the sequencer; the master view is the control unit, ALU and writeback path.
interface alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_dst;
    logic [4:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [63:0] alu_c;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_dst;
    logic [31:0] wb_lo;
    logic [31:0] wb_hi;
    logic        wb_hilo;
    logic        wb_dz;
    logic        err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_dst, alu_c, wb_ready,
        output req_ready, alu_ctrl, alu_a, alu_b,
               wb_valid, wb_dst, wb_lo, wb_hi, wb_hilo, wb_dz, err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_dst, alu_c, wb_ready,
        input  req_ready, alu_ctrl, alu_a, alu_b,
               wb_valid, wb_dst, wb_lo, wb_hi, wb_hilo, wb_dz, err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multicycle owner of the shared ALU: accepts one op, holds the ALU inputs for a
// programmable settle time, captures the 64-bit result and holds it for writeback.
module alu_sequencer #(
    parameter int unsigned EXEC_CYCLES   = 1,
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_NOP  = 5'b11111;
    localparam logic [7:0] EXEC_LOAD   = 8'(EXEC_CYCLES - 1);
    localparam logic [7:0] MULDIV_LOAD = 8'(MULDIV_CYCLES - 1);

    state_t      state, state_next;
    logic [7:0]  cnt;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [3:0]  dst;
    logic [31:0] wb_lo, wb_hi;
    logic [3:0]  wb_dst;
    logic        wb_hilo, wb_dz, err;

    logic        accept, legal, capture, is_muldiv, req_muldiv;
    logic        req_ready, wb_valid;
    logic [4:0]  alu_ctrl;

    function automatic logic op_legal(input logic [4:0] code);
        logic ok;
        case (code)
            5'b00000, 5'b00001, 5'b00010, 5'b00011,
            5'b00100, 5'b00101, 5'b00111, 5'b01000, 5'b01001, 5'b01010,
            5'b01011, 5'b01100, 5'b01101, 5'b01110,
            5'b10010, 5'b10011, 5'b10100: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign legal      = op_legal(bus.req_op);
    assign req_muldiv = (bus.req_op == OP_MUL) || (bus.req_op == OP_DIV);
    assign is_muldiv  = (op == OP_MUL) || (op == OP_DIV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        wb_valid   = 1'b0;
        alu_ctrl   = op;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                alu_ctrl  = OP_NOP;
                accept    = bus.req_valid;
                if (bus.req_valid && legal) state_next = EXEC;
            end
            EXEC: begin
                if (cnt == 8'd0) begin
                    capture    = 1'b1;
                    state_next = WB;
                end
            end
            WB: begin
                wb_valid = 1'b1;
                if (bus.wb_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are latched only on the accept edge; the ALU sees them
    // unchanged until the sequencer is back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            op      <= '0;
            a       <= '0;
            b       <= '0;
            dst     <= '0;
            wb_lo   <= '0;
            wb_hi   <= '0;
            wb_dst  <= '0;
            wb_hilo <= 1'b0;
            wb_dz   <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= accept && !legal;
            if (accept && legal) begin
                op  <= bus.req_op;
                a   <= bus.req_a;
                b   <= bus.req_b;
                dst <= bus.req_dst;
                cnt <= req_muldiv ? MULDIV_LOAD : EXEC_LOAD;
            end else if (state == EXEC && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            // Single-width ops never carry a high word, whatever the ALU leaves there.
            if (capture) begin
                wb_lo   <= bus.alu_c[31:0];
                wb_hi   <= is_muldiv ? bus.alu_c[63:32] : 32'd0;
                wb_dst  <= dst;
                wb_hilo <= is_muldiv;
                wb_dz   <= (op == OP_DIV) && (b == 32'd0);
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.alu_ctrl  = alu_ctrl;
    assign bus.alu_a     = a;
    assign bus.alu_b     = b;
    assign bus.wb_valid  = wb_valid;
    assign bus.wb_dst    = wb_dst;
    assign bus.wb_lo     = wb_lo;
    assign bus.wb_hi     = wb_hi;
    assign bus.wb_hilo   = wb_hilo;
    assign bus.wb_dz     = wb_dz;
    assign bus.err       = err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural ALU and
// a transaction-level model of the expected writeback.
module tb_alu_sequencer;

    localparam int EXEC_N   = 1;
    localparam int MULDIV_N = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    alu_sequencer_if bus();

    alu_sequencer #(.EXEC_CYCLES(EXEC_N), .MULDIV_CYCLES(MULDIV_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [4:0] legalOps [17] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd8, 5'd9,
                                  5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd18, 5'd19, 5'd20};

    function automatic bit isLegal(input logic [4:0] code);
        foreach (legalOps[i]) if (legalOps[i] == code) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit isMulDiv(input logic [4:0] code);
        return code == 5'd2 || code == 5'd3;
    endfunction

    // Stand-in ALU; single-width ops leave junk in the high word on purpose.
    function automatic logic [63:0] aluRef(input logic [4:0] code, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] lo;
        logic [4:0]  sh;
        sh = y[4:0];
        case (code)
            5'd2:  return {32'd0, x} * {32'd0, y};
            5'd3:  return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            5'd0, 5'd18: lo = x + y;
            5'd1:  lo = x - y;
            5'd4, 5'd7: lo = x << sh;
            5'd5:  lo = x >> sh;
            5'd8:  lo = $unsigned($signed(x) >>> sh);
            5'd9:  lo = (x << sh) | ((sh == 0) ? 32'd0 : (x >> (6'd32 - {1'b0, sh})));
            5'd10: lo = (x >> sh) | ((sh == 0) ? 32'd0 : (x << (6'd32 - {1'b0, sh})));
            5'd11, 5'd19: lo = x & y;
            5'd12, 5'd20: lo = x | y;
            5'd13: lo = ~x;
            5'd14: lo = -x;
            default: return 64'h0BAD_0BAD_0BAD_0BAD;
        endcase
        return {27'h600_0DE, code, lo};
    endfunction

    always_comb bus.alu_c = aluRef(bus.alu_ctrl, bus.alu_a, bus.alu_b);

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] dst, input int hold);
        logic [63:0] full;
        logic [31:0] expHi;
        int cycles, n;
        bit stable;
        full   = aluRef(op, a, b);
        expHi  = isMulDiv(op) ? full[63:32] : 32'd0;
        n      = isMulDiv(op) ? MULDIV_N : EXEC_N;
        @(negedge clk);
        checkOutput("idle_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_dst = dst;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op = 5'($urandom); bus.req_a = $urandom; bus.req_b = $urandom; bus.req_dst = 4'($urandom);
        checkOutput("exec_inputs", {bus.alu_ctrl, bus.alu_a, bus.alu_b}, {op, a, b});
        checkOutput("exec_flags", {bus.req_ready, bus.err}, 0);
        cycles = 0;
        stable = 1'b1;
        while (!bus.wb_valid && cycles < 40) begin
            if ({bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.req_ready} !== {op, a, b, 1'b0}) stable = 1'b0;
            bus.req_valid = 1'($urandom);
            bus.req_op = 5'($urandom); bus.req_a = $urandom; bus.req_b = $urandom;
            @(negedge clk);
            cycles++;
        end
        bus.req_valid = 1'b0;
        checkOutput("exec_hold", stable, 1);
        checkOutput("latency", cycles, n);
        checkOutput("wb_data", {bus.wb_hi, bus.wb_lo}, {expHi, full[31:0]});
        checkOutput("wb_ctl", {bus.wb_dst, bus.wb_hilo, bus.wb_dz},
                    {dst, isMulDiv(op), (op == 5'd3) && (b == 0)});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("wb_stall", {bus.wb_valid, bus.req_ready, bus.wb_hi, bus.wb_lo, bus.wb_dst},
                        {1'b1, 1'b0, expHi, full[31:0], dst});
        end
        bus.wb_ready = 1'b1;
        @(negedge clk);
        bus.wb_ready = 1'b0;
        checkOutput("wb_release", {bus.wb_valid, bus.req_ready, bus.alu_ctrl}, {1'b0, 1'b1, 5'h1F});
    endtask

    task automatic applyIllegal(input logic [4:0] op);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = $urandom; bus.req_b = $urandom;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checkOutput("illegal_err", {bus.err, bus.req_ready, bus.wb_valid, bus.alu_ctrl},
                    {1'b1, 1'b1, 1'b0, 5'h1F});
        @(negedge clk);
        checkOutput("illegal_after", {bus.err, bus.req_ready, bus.wb_valid}, {1'b0, 1'b1, 1'b0});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput(tag, {bus.req_ready, bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.wb_valid},
                    {1'b1, 5'h1F, 64'd0, 1'b0});
        checkOutput({tag, "_wb"}, {bus.wb_lo, bus.wb_hi, bus.wb_dst, bus.wb_hilo, bus.wb_dz, bus.err}, 0);
    endtask

    task automatic applyClearDuringMul();
        bit quiet;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 5'd2; bus.req_a = 32'h1234; bus.req_b = 32'h55; bus.req_dst = 4'd9;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetValues("clear_exec");
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.wb_valid !== 1'b0) quiet = 1'b0;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.wb_valid !== 1'b0) quiet = 1'b0;
        end
        checkOutput("clear_no_wb", quiet, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_dst = '0;
        bus.wb_ready = 1'b0;
        #1 checkResetValues("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(5'd0, 32'd5, 32'd7, 4'd3, 0);
        applyStimulus(5'd2, 32'h0001_0000, 32'h0001_0000, 4'd6, 0);
        applyStimulus(5'd3, 32'd7, 32'd0, 4'd2, 1);
        applyStimulus(5'd3, 32'd7, 32'd2, 4'd4, 0);
        applyIllegal(5'b01111);
        applyStimulus(5'd0, 32'd100, 32'hFFFF_FFFF, 4'd1, 3);
        applyClearDuringMul();
        applyStimulus(5'd1, 32'd9, 32'd4, 4'd5, 0);
        applyIllegal(5'b00110);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do op = 5'($urandom); while (isLegal(op));
                applyIllegal(op);
            end else begin
                op = legalOps[$urandom_range(0, 16)];
                a  = $urandom;
                b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
                applyStimulus(op, a, b, 4'($urandom), int'($urandom_range(0, 3)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
